// File: rtl/aes_pkg.sv
// Shared AES decrypt-side definitions: step count, FSM states, inverse S-box,
// GF(2^8) multipliers and byte/column index helpers.
package aes_pkg;

  localparam int NUM_STEPS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Row r of column c lives at byte 4c+r of the 128-bit state.
  function automatic int byte_idx(input int col, input int row);
    return 4 * col + row;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3)};
  endfunction

endpackage

// File: rtl/aes_dec_step.sv
// One combinational AES inverse step:
// InvSubBytes(InvShiftRows(InvMixColumns(cxx ^ key))).
module aes_dec_step
  import aes_pkg::*;
(
  input  logic [127:0] cxx,
  input  logic [127:0] key,
  output logic [127:0] dec
);

  logic [127:0] ark;
  logic [127:0] imc;

  always_comb begin
    ark = cxx ^ key;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[32*c +: 32] = inv_mix_column(ark[32*c +: 32]);
    end
  end

  // Row r is rotated right by r columns on its way into the S-box lookup.
  always_comb begin
    dec = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        dec[8*byte_idx(c, r) +: 8] = inv_sbox(imc[8*byte_idx((c + 4 - r) % 4, r) +: 8]);
      end
    end
  end

endmodule

// File: rtl/aes_dec_round.sv
// Iterative AES inverse-round engine: ten inverse steps, one per clock,
// consuming round keys k9 down to k0.
module aes_dec_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] xin,
  input  logic [127:0] k0,
  input  logic [127:0] k1,
  input  logic [127:0] k2,
  input  logic [127:0] k3,
  input  logic [127:0] k4,
  input  logic [127:0] k5,
  input  logic [127:0] k6,
  input  logic [127:0] k7,
  input  logic [127:0] k8,
  input  logic [127:0] k9,
  output logic         busy,
  output logic         done,
  output logic [127:0] xout
);

  state_t       state;
  state_t       state_next;
  logic [3:0]   cnt;
  logic [127:0] state_reg;
  logic [127:0] round_key;
  logic [127:0] step_out;
  logic         last;
  logic         load;
  logic         advance;
  logic         finish;

  // Out-of-range counts finish the run exactly like a count of zero.
  assign last = (cnt == 4'd0) || (cnt >= 4'(NUM_STEPS));

  always_comb begin
    case (cnt)
      4'd1:    round_key = k1;
      4'd2:    round_key = k2;
      4'd3:    round_key = k3;
      4'd4:    round_key = k4;
      4'd5:    round_key = k5;
      4'd6:    round_key = k6;
      4'd7:    round_key = k7;
      4'd8:    round_key = k8;
      4'd9:    round_key = k9;
      default: round_key = k0;
    endcase
  end

  aes_dec_step u_step (
    .cxx (state_reg),
    .key (round_key),
    .dec (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: load = start;
      RUN: begin
        busy    = 1'b1;
        advance = 1'b1;
        finish  = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      cnt       <= '0;
      xout      <= '0;
      done      <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        state_reg <= xin;
        cnt       <= 4'(NUM_STEPS - 1);
      end else if (advance) begin
        state_reg <= step_out;
        cnt       <= last ? 4'd0 : cnt - 4'd1;
      end
      if (finish) xout <= step_out;
    end
  end

endmodule

// File: tb/tb_aes_dec_round.sv
// Self-checking bench for aes_dec_round and aes_dec_step against a GF(2^8)
// arithmetic reference model of the AES round and its inverse.
module tb_aes_dec_round;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] xin;
  logic [127:0] keys [10];
  logic         busy;
  logic         done;
  logic [127:0] xout;
  logic [127:0] step_cxx;
  logic [127:0] step_key;
  logic [127:0] step_dec;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_count   = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  aes_dec_round dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .xin   (xin),
    .k0    (keys[0]),
    .k1    (keys[1]),
    .k2    (keys[2]),
    .k3    (keys[3]),
    .k4    (keys[4]),
    .k5    (keys[5]),
    .k6    (keys[6]),
    .k7    (keys[7]),
    .k8    (keys[8]),
    .k9    (keys[9]),
    .busy  (busy),
    .done  (done),
    .xout  (xout)
  );

  aes_dec_step u_step_ut (
    .cxx (step_cxx),
    .key (step_key),
    .dec (step_dec)
  );

  always @(negedge clk) if (done === 1'b1) done_count++;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    d = d << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (a != 8'h00 && gf_mul(a, 8'(x)) == 8'h01) inv = 8'(x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] mix_coef(input bit inverse, input int r, input int j);
    case ((j - r + 4) % 4)
      0:       return inverse ? 8'h0e : 8'h02;
      1:       return inverse ? 8'h0b : 8'h03;
      2:       return inverse ? 8'h0d : 8'h01;
      default: return inverse ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
    return s[8*(4*c + r) +: 8];
  endfunction

  function automatic logic [127:0] mix_all(input logic [127:0] t, input bit inverse);
    logic [127:0] u;
    logic [7:0]   acc;
    u = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(mix_coef(inverse, r, j), gb(t, j, c));
        u[8*(4*c + r) +: 8] = acc;
      end
    return u;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] x, input logic [127:0] k);
    logic [127:0] sr;
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[8*(4*c + r) +: 8] = sbox_t[gb(x, r, (c + r) % 4)];
    return mix_all(sr, 1'b0) ^ k;
  endfunction

  function automatic logic [127:0] ref_dec(input logic [127:0] y, input logic [127:0] k);
    logic [127:0] u;
    logic [127:0] v;
    u = mix_all(y ^ k, 1'b1);
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[8*(4*c + r) +: 8] = isbox_t[gb(u, r, (c + 4 - r) % 4)];
    return v;
  endfunction

  function automatic logic [127:0] ref_run(input logic [127:0] x);
    logic [127:0] s;
    s = x;
    for (int i = 9; i >= 0; i--) s = ref_dec(s, keys[i]);
    return s;
  endfunction

  function automatic logic [127:0] ref_enc_run(input logic [127:0] x);
    logic [127:0] s;
    s = x;
    for (int i = 0; i < 10; i++) s = ref_enc(s, keys[i]);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- bench tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] x, input logic [127:0] exp, input string tag);
    int busy_n;
    int d0;
    d0    = done_count;
    xin   = x;
    start = 1'b1;
    tick();
    start  = 1'b0;
    xin    = rand128();
    busy_n = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      tick();
      if (busy === 1'b1) busy_n++;
    end
    tick();
    checkOutput({tag, ".busy_cycles"}, 128'(busy_n), 128'd10);
    checkOutput({tag, ".done"}, 128'(done), 128'd1);
    checkOutput({tag, ".busy_end"}, 128'(busy), 128'd0);
    checkOutput({tag, ".xout"}, xout, exp);
    tick();
    checkOutput({tag, ".done_pulses"}, 128'(done_count - d0), 128'd1);
  endtask

  task automatic randomKeys();
    for (int i = 0; i < 10; i++) keys[i] = rand128();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] x1;
    logic [127:0] x2;
    logic [127:0] exp;
    logic [127:0] last_exp;
    logic [127:0] v [44];
    int           d0;

    rst   = 1'b1;
    start = 1'b0;
    xin   = '0;
    for (int i = 0; i < 10; i++) keys[i] = '0;
    step_cxx = '0;
    step_key = '0;

    for (int a = 0; a < 256; a++) begin
      sbox_t[a] = sbox_calc(8'(a));
      isbox_t[sbox_t[a]] = 8'(a);
    end

    // reset state
    tick();
    tick();
    checkOutput("reset.busy", 128'(busy), 128'd0);
    checkOutput("reset.done", 128'(done), 128'd0);
    checkOutput("reset.xout", xout, 128'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle.busy", 128'(busy), 128'd0);

    // standalone step: known InvMixColumns column, zero key
    step_cxx = {4{32'hbca14d8e}};
    step_key = '0;
    #1;
    checkOutput("step.vector", step_dec, {4{32'h6850829f}});
    for (int i = 0; i < 4; i++) begin
      step_cxx = rand128();
      step_key = rand128();
      #1;
      checkOutput($sformatf("step.random%0d", i), step_dec, ref_dec(step_cxx, step_key));
    end

    // all-zero keys and input
    applyStimulus(128'd0, ref_run(128'd0), "zero");

    // round trip through the encrypt model
    for (int i = 0; i < 10; i++) keys[i] = 128'h0f0e0d0c0b0a09080706050403020100 + 128'(i);
    x1 = ref_enc_run(128'h00112233445566778899aabbccddeeff);
    applyStimulus(x1, 128'h00112233445566778899aabbccddeeff, "roundtrip");

    // random jobs with random keys
    for (int j = 0; j < 3; j++) begin
      randomKeys();
      x1 = rand128();
      applyStimulus(x1, ref_run(x1), $sformatf("random%0d", j));
    end

    // a start pulse mid-run must be dropped
    randomKeys();
    x1 = rand128();
    x2 = rand128();
    d0 = done_count;
    xin = x1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) begin
        start = 1'b1;
        xin   = x2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    checkOutput("midstart.done", 128'(done), 128'd1);
    checkOutput("midstart.xout", xout, ref_run(x1));
    last_exp = ref_run(x1);
    repeat (4) tick();
    checkOutput("midstart.pulses", 128'(done_count - d0), 128'd1);
    checkOutput("midstart.idle", 128'(busy), 128'd0);

    // reset mid-run, then a fresh job accepted as reset releases
    randomKeys();
    x1 = rand128();
    x2 = rand128();
    d0 = done_count;
    xin = x1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort.busy", 128'(busy), 128'd0);
    checkOutput("abort.done", 128'(done), 128'd0);
    checkOutput("abort.xout", xout, 128'd0);
    start = 1'b1;
    xin   = x2;
    tick();
    rst = 1'b0;
    applyStimulus(x2, ref_run(x2), "after_abort");
    checkOutput("abort.total_pulses", 128'(done_count - d0), 128'd1);
    last_exp = ref_run(x2);

    // start held high: re-trigger every 11 cycles, xout stable in between
    randomKeys();
    start = 1'b1;
    for (int n = 0; n < 44; n++) begin
      if (n == 40) start = 1'b0;
      v[n] = rand128();
      xin  = v[n];
      tick();
      if (n == 10 || n == 21 || n == 32 || n == 43) begin
        exp = ref_run(v[n-10]);
        checkOutput($sformatf("held.done@%0d", n), 128'(done), 128'd1);
        checkOutput($sformatf("held.xout@%0d", n), xout, exp);
        last_exp = exp;
      end else begin
        checkOutput($sformatf("held.nodone@%0d", n), 128'(done), 128'd0);
        checkOutput($sformatf("held.stable@%0d", n), xout, last_exp);
      end
    end
    tick();
    checkOutput("held.final_idle", 128'(busy), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
